bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one input bit per cycle) that sits between the CPU datapath values and the `seg7` digit decoders. It replaces the combinational `/` and `%` chains that currently feed the displays. One instance serves the PC pair of digits, and one serves the four write-data digits. Each digit is presented as a registered 4-bit BCD nibble that is held stable between conversions.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 17 +
 rtl/bin2bcd_seq.sv | 125 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, digit width and the add-3 threshold.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Per-digit adjust step of shift-and-add-3: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= ADD3_THRESH) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per cycle.
// Define BIN2BCD_OVF_EN to add the ovf port (result truncated to NUM_DIG digits).
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int NUM_DIG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IN_W-1:0]      bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NUM_DIG-1:0] bcd
`ifdef BIN2BCD_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * NUM_DIG;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t state;
    state_t state_nxt;

    logic [IN_W-1:0]  in_sr;
    logic [BCD_W-1:0] work;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] work_shift;
    logic [CNT_W-1:0] cnt;
    logic             carry_out;
    logic             load;
    logic             shift_en;
    logic             last;

    for (genvar d = 0; d < NUM_DIG; d++) begin : g_adj
        bcd_add3 u_add3 (
            .digit    (work[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // carry_out is the bit pushed off the top digit; it only matters for overflow
    assign {carry_out, work_shift} = {adj, in_sr[IN_W-1]};
    assign last = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BIN2BCD_OVF_EN
    logic ovf_flag;
`else
    logic unused_carry;
    assign unused_carry = carry_out;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_sr <= '0;
            work  <= '0;
            cnt   <= '0;
            bcd   <= '0;
`ifdef BIN2BCD_OVF_EN
            ovf_flag <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else if (load) begin
            in_sr <= bin;
            work  <= '0;
            cnt   <= CNT_W'(IN_W);
`ifdef BIN2BCD_OVF_EN
            ovf_flag <= 1'b0;
`endif
        end else if (shift_en) begin
            in_sr <= in_sr << 1;
            work  <= work_shift;
            cnt   <= cnt - CNT_W'(1);
`ifdef BIN2BCD_OVF_EN
            ovf_flag <= ovf_flag | carry_out;
`endif
            if (last) begin
                bcd <= work_shift;
`ifdef BIN2BCD_OVF_EN
                ovf <= ovf_flag | carry_out;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three parameterisations checked against
// a decimal-digit reference model.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [63:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t q_m[$];
    exp_t q_w[$];
    exp_t q_s[$];

    // Main instance: 16-bit in, 4 digits
    logic        rst, start;
    logic [15:0] bin;
    logic        busy, done;
    logic [15:0] bcd;
    // Wide instance: 32-bit in, 10 digits
    logic        rst_w, start_w;
    logic [31:0] bin_w;
    logic        busy_w, done_w;
    logic [39:0] bcd_w;
    // Small instance: 7-bit in, 2 digits
    logic        rst_s, start_s;
    logic [6:0]  bin_s;
    logic        busy_s, done_s;
    logic [7:0]  bcd_s;
`ifdef BIN2BCD_OVF_EN
    logic ovf, ovf_w, ovf_s;
`endif

    bin2bcd_seq #(.IN_W(16), .NUM_DIG(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
`ifdef BIN2BCD_OVF_EN
        , .ovf(ovf)
`endif
    );

    bin2bcd_seq #(.IN_W(32), .NUM_DIG(10)) dut_w (
        .clk(clk), .rst(rst_w), .start(start_w), .bin(bin_w),
        .busy(busy_w), .done(done_w), .bcd(bcd_w)
`ifdef BIN2BCD_OVF_EN
        , .ovf(ovf_w)
`endif
    );

    bin2bcd_seq #(.IN_W(7), .NUM_DIG(2)) dut_s (
        .clk(clk), .rst(rst_s), .start(start_s), .bin(bin_s),
        .busy(busy_s), .done(done_s), .bcd(bcd_s)
`ifdef BIN2BCD_OVF_EN
        , .ovf(ovf_s)
`endif
    );

    // Reference: decimal digits of v, least significant first; ovf when v needs more digits.
    function automatic exp_t model(input longint unsigned v, input int nd);
        exp_t e;
        longint unsigned p;
        p     = 1;
        e.bcd = '0;
        for (int k = 0; k < nd; k++) begin
            e.bcd[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        e.ovf = (v >= p);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic report_fail(input string name, input string detail);
        n_total++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // Monitors: pop one expectation per done pulse
    always @(negedge clk) begin : mon_m
        exp_t e;
        if (busy && done) report_fail("overlap_m", "busy=1 done=1, expected never both");
        if (done) begin
            if (q_m.size() == 0) report_fail("spurious_done_m", "done=1, expected no pending conversion");
            else begin
                e = q_m.pop_front();
                check("bcd16", 64'(bcd), e.bcd);
`ifdef BIN2BCD_OVF_EN
                check("ovf16", 64'(ovf), 64'(e.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin : mon_w
        exp_t e;
        if (busy_w && done_w) report_fail("overlap_w", "busy=1 done=1, expected never both");
        if (done_w) begin
            if (q_w.size() == 0) report_fail("spurious_done_w", "done=1, expected no pending conversion");
            else begin
                e = q_w.pop_front();
                check("bcd40", 64'(bcd_w), e.bcd);
`ifdef BIN2BCD_OVF_EN
                check("ovf40", 64'(ovf_w), 64'(e.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin : mon_s
        exp_t e;
        if (busy_s && done_s) report_fail("overlap_s", "busy=1 done=1, expected never both");
        if (done_s) begin
            if (q_s.size() == 0) report_fail("spurious_done_s", "done=1, expected no pending conversion");
            else begin
                e = q_s.pop_front();
                check("bcd8", 64'(bcd_s), e.bcd);
`ifdef BIN2BCD_OVF_EN
                check("ovf8", 64'(ovf_s), 64'(e.ovf));
`endif
            end
        end
    end

    task automatic wait_idle_m();
        int w;
        w = 0;
        while ((busy || done) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (busy || done) report_fail("idle_timeout_m", "still busy after 100 cycles, expected idle");
    endtask

    // One conversion on the main instance; glitch pulses start (bin=42) in
    // SHIFT cycle 5 and in the DONE cycle, both of which must be ignored.
    task automatic convert(input logic [15:0] v, input bit glitch);
        int  ncyc;
        bit  seen;
        wait_idle_m();
        start = 1'b1;
        bin   = v;
        q_m.push_back(model(longint'(v), 4));
        @(negedge clk);
        start = 1'b0;
        bin   = 16'($urandom);
        ncyc  = 0;
        seen  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) ncyc++;
            start = glitch && (c == 5 || done);
            if (start) bin = 16'd42;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_cycles", 64'(ncyc), 64'd16);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic convert_abort(input logic [15:0] v, input int at);
        int ndone;
        wait_idle_m();
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        repeat (at - 1) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_bcd", 64'(bcd), 64'd0);
`ifdef BIN2BCD_OVF_EN
        check("abort_ovf", 64'(ovf), 64'd0);
`endif
        rst   = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
    endtask

    initial begin
        int w;
        rst = 1'b0; start = 1'b0; bin = '0;
        rst_w = 1'b0; start_w = 1'b0; bin_w = '0;
        rst_s = 1'b0; start_s = 1'b0; bin_s = '0;
        repeat (2) @(negedge clk);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
`ifdef BIN2BCD_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst = 1'b1; rst_w = 1'b1; rst_s = 1'b1;

        convert(16'd0, 1'b0);
        convert(16'd1234, 1'b0);
        convert(16'd9999, 1'b0);
        convert(16'd10000, 1'b0);
        convert(16'd65535, 1'b0);
        convert(16'd1234, 1'b1);
        convert(16'd42, 1'b0);
        convert(16'd1234, 1'b0);
        convert_abort(16'd5678, 8);
        convert(16'd5678, 1'b0);
        for (int i = 0; i < 30; i++) convert(16'($urandom), 1'b0);

        for (int i = 0; i < 1000; i++) begin
            w = 0;
            while ((busy_w || done_w) && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (busy_w || done_w) report_fail("idle_timeout_w", "still busy after 100 cycles, expected idle");
            start_w = 1'b1;
            bin_w   = $urandom;
            q_w.push_back(model(longint'(bin_w), 10));
            @(negedge clk);
            start_w = 1'b0;
            bin_w   = $urandom;
        end

        for (int v = 127; v >= 0; v--) begin
            w = 0;
            while ((busy_s || done_s) && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (busy_s || done_s) report_fail("idle_timeout_s", "still busy after 100 cycles, expected idle");
            start_s = 1'b1;
            bin_s   = 7'(v);
            q_s.push_back(model(longint'(v), 2));
            @(negedge clk);
            start_s = 1'b0;
            bin_s   = 7'($urandom);
        end

        w = 0;
        while ((q_m.size() + q_w.size() + q_s.size()) != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (q_m.size() != 0) report_fail("drain_m", $sformatf("%0d results outstanding, expected 0", q_m.size()));
        if (q_w.size() != 0) report_fail("drain_w", $sformatf("%0d results outstanding, expected 0", q_w.size()));
        if (q_s.size() != 0) report_fail("drain_s", $sformatf("%0d results outstanding, expected 0", q_s.size()));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
